// File: rtl/servile_mem_scheduler_pkg.sv
// Shared arbiter definitions: grant-state encodings, grant bit indices and the arbitration pick.
package servile_mem_scheduler_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GNT_CPU = 2'b01;
    localparam logic [1:0] ST_GNT_AUX = 2'b10;

    localparam int unsigned GNT_CPU = 0;
    localparam int unsigned GNT_AUX = 1;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_AUX = 1'b1;

    // Next grant state for the requests seen while idle.
    function automatic logic [1:0] arb_pick(input logic cpu_stb, input logic aux_stb,
                                            input logic last_served, input logic fixed_prio);
        logic [1:0] pick;
        pick = ST_IDLE;
        if (cpu_stb && aux_stb) begin
            pick = (fixed_prio || last_served == LAST_AUX) ? ST_GNT_CPU : ST_GNT_AUX;
        end else if (cpu_stb) begin
            pick = ST_GNT_CPU;
        end else if (aux_stb) begin
            pick = ST_GNT_AUX;
        end
        return pick;
    endfunction

endpackage

// File: rtl/servile_mem_scheduler_timer.sv
// Grant watchdog: cleared while idle, counts granted cycles without ack, flags the last allowed one.
module servile_mem_scheduler_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry fires during the TIMEOUT-th counted cycle, so the count only needs to reach TIMEOUT-1.
    assign o_expire = i_en && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servile_mem_scheduler.sv
// Two-master Wishbone arbiter in front of the servile SPI RAM slave port.
// Optional grant watchdog enabled by defining SERVILE_ARB_TIMEOUT_EN.
module servile_mem_scheduler
    import servile_mem_scheduler_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_cpu_adr,
    input  logic [31:0]   i_cpu_dat,
    input  logic [3:0]    i_cpu_sel,
    input  logic          i_cpu_we,
    input  logic          i_cpu_stb,
    output logic [31:0]   o_cpu_rdt,
    output logic          o_cpu_ack,
    input  logic [AW-1:0] i_aux_adr,
    input  logic [31:0]   i_aux_dat,
    input  logic [3:0]    i_aux_sel,
    input  logic          i_aux_we,
    input  logic          i_aux_stb,
    output logic [31:0]   o_aux_rdt,
    output logic          o_aux_ack,
    output logic [AW-1:0] o_mem_adr,
    output logic [31:0]   o_mem_dat,
    output logic [3:0]    o_mem_sel,
    output logic          o_mem_we,
    output logic          o_mem_stb,
    input  logic [31:0]   i_mem_rdt,
    input  logic          i_mem_ack,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;
    logic       last_d;
    logic       grant_cpu;
    logic       grant_aux;
    logic       cur_stb;
    logic       force_done;

    assign grant_cpu = (state_q == ST_GNT_CPU);
    assign grant_aux = (state_q == ST_GNT_AUX);
    assign cur_stb   = (grant_cpu && i_cpu_stb) || (grant_aux && i_aux_stb);

`ifdef SERVILE_ARB_TIMEOUT_EN
    logic expire;

    servile_mem_scheduler_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (state_q == ST_IDLE),
        .i_en     ((grant_cpu || grant_aux) && !i_mem_ack),
        .o_expire (expire)
    );

    // A real ack in the expiry cycle wins; a dropped stb is an abort, not a timeout.
    assign force_done = expire && cur_stb && !i_mem_ack;
`else
    assign force_done = 1'b0;
`endif

    assign o_timeout = force_done;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                state_d = arb_pick(i_cpu_stb, i_aux_stb, last_q, FIXED_PRIO != 0);
            end
            ST_GNT_CPU: begin
                if (i_mem_ack || force_done) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_CPU;
                end else if (!i_cpu_stb) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_AUX: begin
                if (i_mem_ack || force_done) begin
                    state_d = ST_IDLE;
                    last_d  = LAST_AUX;
                end else if (!i_aux_stb) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_AUX;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        o_mem_adr = '0;
        o_mem_dat = '0;
        o_mem_sel = '0;
        o_mem_we  = 1'b0;
        o_mem_stb = 1'b0;
        if (grant_cpu) begin
            o_mem_adr = i_cpu_adr;
            o_mem_dat = i_cpu_dat;
            o_mem_sel = i_cpu_sel;
            o_mem_we  = i_cpu_we;
            o_mem_stb = i_cpu_stb && !force_done;
        end else if (grant_aux) begin
            o_mem_adr = i_aux_adr;
            o_mem_dat = i_aux_dat;
            o_mem_sel = i_aux_sel;
            o_mem_we  = i_aux_we;
            o_mem_stb = i_aux_stb && !force_done;
        end
    end

    always_comb begin
        o_grant          = 2'b00;
        o_grant[GNT_CPU] = grant_cpu;
        o_grant[GNT_AUX] = grant_aux;
    end

    assign o_cpu_ack = grant_cpu && (i_mem_ack || force_done);
    assign o_aux_ack = grant_aux && (i_mem_ack || force_done);
    assign o_cpu_rdt = (grant_cpu && !force_done) ? i_mem_rdt : 32'h0;
    assign o_aux_rdt = (grant_aux && !force_done) ? i_mem_rdt : 32'h0;

endmodule

// File: tb/tb_servile_mem_scheduler.sv
// Directed bench: round-robin instance plus a fixed-priority instance driven by the same stimulus.
module tb_servile_mem_scheduler;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_adr, aux_adr;
    logic [31:0]   cpu_dat, aux_dat, mem_rdt;
    logic [3:0]    cpu_sel, aux_sel;
    logic          cpu_we, cpu_stb, aux_we, aux_stb, mem_ack;

    logic [31:0]   cpu_rdt, aux_rdt, mem_dat;
    logic          cpu_ack, aux_ack, mem_we, mem_stb, timeout;
    logic [AW-1:0] mem_adr;
    logic [3:0]    mem_sel;
    logic [1:0]    grant;

    logic [31:0]   fp_cpu_rdt, fp_aux_rdt, fp_mem_dat;
    logic          fp_cpu_ack, fp_aux_ack, fp_mem_we, fp_mem_stb, fp_timeout;
    logic [AW-1:0] fp_mem_adr;
    logic [3:0]    fp_mem_sel;
    logic [1:0]    fp_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servile_mem_scheduler #(.AW(AW), .FIXED_PRIO(0), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
        .i_cpu_stb(cpu_stb), .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
        .i_aux_adr(aux_adr), .i_aux_dat(aux_dat), .i_aux_sel(aux_sel), .i_aux_we(aux_we),
        .i_aux_stb(aux_stb), .o_aux_rdt(aux_rdt), .o_aux_ack(aux_ack),
        .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel), .o_mem_we(mem_we),
        .o_mem_stb(mem_stb), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
        .o_grant(grant), .o_timeout(timeout)
    );

    servile_mem_scheduler #(.AW(AW), .FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
        .i_cpu_stb(cpu_stb), .o_cpu_rdt(fp_cpu_rdt), .o_cpu_ack(fp_cpu_ack),
        .i_aux_adr(aux_adr), .i_aux_dat(aux_dat), .i_aux_sel(aux_sel), .i_aux_we(aux_we),
        .i_aux_stb(aux_stb), .o_aux_rdt(fp_aux_rdt), .o_aux_ack(fp_aux_ack),
        .o_mem_adr(fp_mem_adr), .o_mem_dat(fp_mem_dat), .o_mem_sel(fp_mem_sel),
        .o_mem_we(fp_mem_we), .o_mem_stb(fp_mem_stb), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
        .o_grant(fp_grant), .o_timeout(fp_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_stb = 1'b1;
        aux_adr = '0; aux_dat = '0; aux_sel = '0; aux_we = 1'b0; aux_stb = 1'b1;
        mem_rdt = '0; mem_ack = 1'b0;

        // 1: reset held with both masters requesting
        repeat (3) next_cyc();
        sample();
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_stb", mem_stb, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_acks", {cpu_ack, aux_ack}, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        next_cyc();
        cpu_stb = 1'b0; aux_stb = 1'b0;
        rst_n   = 1'b1;
        next_cyc();

        // 2: CPU read, ack in third granted cycle
        cpu_adr = 32'h100; cpu_stb = 1'b1;
        sample();
        chk("rd_idle_stb", mem_stb, 1'b0);
        next_cyc();
        sample();
        chk("rd_grant", grant, 2'b01);
        chk("rd_mem_stb", mem_stb, 1'b1);
        chk("rd_mem_adr", mem_adr, 32'h100);
        chk("rd_no_ack_early", cpu_ack, 1'b0);
        next_cyc();
        next_cyc();
        mem_ack = 1'b1; mem_rdt = 32'hDEADBEEF;
        sample();
        chk("rd_cpu_ack", cpu_ack, 1'b1);
        chk("rd_cpu_rdt", cpu_rdt, 32'hDEADBEEF);
        chk("rd_aux_ack", aux_ack, 1'b0);
        chk("rd_aux_rdt", aux_rdt, 32'h0);
        next_cyc();
        mem_ack = 1'b0; mem_rdt = '0; cpu_stb = 1'b0;
        sample();
        chk("rd_back_idle", grant, 2'b00);
        chk("rd_ack_done", cpu_ack, 1'b0);

        // 4: AUX write
        next_cyc();
        aux_adr = 32'h40; aux_dat = 32'h12345678; aux_sel = 4'b0011; aux_we = 1'b1;
        aux_stb = 1'b1;
        next_cyc();
        sample();
        chk("wr_grant", grant, 2'b10);
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_sel", mem_sel, 4'b0011);
        chk("wr_mem_adr", mem_adr, 32'h40);
        chk("wr_mem_dat", mem_dat, 32'h12345678);
        next_cyc();
        mem_ack = 1'b1;
        sample();
        chk("wr_aux_ack", aux_ack, 1'b1);
        chk("wr_cpu_ack", cpu_ack, 1'b0);
        next_cyc();
        mem_ack = 1'b0; aux_stb = 1'b0; aux_we = 1'b0;
        sample();
        chk("wr_idle_ack_ignored", {grant, aux_ack}, 3'b000);

        // 3: both masters request continuously, slave acks every granted cycle
        next_cyc();
        cpu_stb = 1'b1; aux_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_ack = i[0];
            sample();
            if (i[0] == 1'b0) begin
                chk($sformatf("rr_idle%0d", i), grant, 2'b00);
                chk($sformatf("fp_idle%0d", i), fp_grant, 2'b00);
            end else begin
                chk($sformatf("rr_grant%0d", i), grant, (i % 4 == 1) ? 2'b01 : 2'b10);
                chk($sformatf("fp_grant%0d", i), fp_grant, 2'b01);
            end
            next_cyc();
        end
        mem_ack = 1'b0; cpu_stb = 1'b0; aux_stb = 1'b0;
        next_cyc();

        // 5: CPU aborts, pending AUX served next
        cpu_stb = 1'b1; aux_stb = 1'b1;
        next_cyc();
        sample();
        chk("ab_grant_cpu", grant, 2'b01);
        next_cyc();
        cpu_stb = 1'b0;
        sample();
        chk("ab_mem_stb_low", mem_stb, 1'b0);
        chk("ab_no_ack", cpu_ack, 1'b0);
        next_cyc();
        sample();
        chk("ab_idle", grant, 2'b00);
        next_cyc();
        sample();
        chk("ab_aux_granted", grant, 2'b10);
        mem_ack = 1'b1;
        #1;
        chk("ab_aux_ack", aux_ack, 1'b1);
        next_cyc();
        mem_ack = 1'b0; aux_stb = 1'b0;
        next_cyc();

        // 6: slave never acks
        cpu_stb = 1'b1; mem_rdt = 32'hFFFFFFFF;
        next_cyc();
        for (int k = 1; k < 8; k++) begin
            sample();
            chk($sformatf("to_wait%0d", k), {grant, cpu_ack, timeout}, 4'b0100);
            next_cyc();
        end
        sample();
`ifdef SERVILE_ARB_TIMEOUT_EN
        chk("to_cpu_ack", cpu_ack, 1'b1);
        chk("to_cpu_rdt", cpu_rdt, 32'h0);
        chk("to_pulse", timeout, 1'b1);
        chk("to_mem_stb", mem_stb, 1'b0);
        next_cyc();
        sample();
        chk("to_idle", {grant, timeout}, 3'b000);
`else
        chk("to_cpu_ack", cpu_ack, 1'b0);
        chk("to_pulse", timeout, 1'b0);
        chk("to_mem_stb", mem_stb, 1'b1);
        next_cyc();
        sample();
        chk("to_held", {grant, timeout}, 3'b010);
`endif
        cpu_stb = 1'b0; mem_rdt = '0;
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
